mem_port_arbiter: RTL and testbench

Arbitrates a single-port synchronous memory between the instruction-fetch port and the load/store port of the RV32I core, for the multi-cycle core variant where instruction and data memory are merged.

- Round-robin arbitration on simultaneous requests.
- Request/grant/response handshake per port.
- Configurable number of memory wait states.
- Sits between the core's fetch/LSU logic and the shared memory macro.
- The core stalls on each port until that port sees `rvalid`.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/LSU ports, the arbiter and the shared
// single-port memory macro. Signal names are as seen from the arbiter
// (i_ = into the arbiter, o_ = out of it).
//   fetch port : i_if_req, i_if_addr -> o_if_gnt, o_if_rvalid, o_if_rdata
//   ls port    : i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask
//                -> o_ls_gnt, o_ls_rvalid, o_ls_rdata
//   memory     : o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask <- i_mem_rdata
// Modports: slave = the arbiter, master = everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_ls_req;
  logic              i_ls_wren;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic [3:0]        i_ls_bmask;
  logic              o_ls_gnt;
  logic              o_ls_rvalid;
  logic [DATA_W-1:0] o_ls_rdata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wren;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch port and the
// load/store port of the multi-cycle RV32I core. One access is in flight at a
// time: IDLE (grant) -> ACCESS (1+WAIT_CYCLES cycles) -> RESP (rvalid) -> IDLE.
// Ties are broken round-robin so neither port can starve.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (fetch, load/store and memory sides)
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_ls;   // 1: last grant went to load/store
  logic              r_own_ls;    // owner of the access in flight
  logic              r_wren;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_bmask;

  logic              w_gnt_if, w_gnt_ls, w_first;
  logic              w_if_rvalid, w_ls_rvalid, w_mem_wren;
  logic [DATA_W-1:0] w_if_rdata, w_ls_rdata, w_mem_wdata;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [3:0]        w_mem_bmask;

  // Grants are combinational in IDLE; gated by reset so all outputs drop at once.
  assign w_gnt_if = i_rst_n && (r_state == S_IDLE) && bus.i_if_req &&
                    (!bus.i_ls_req || r_last_ls);
  assign w_gnt_ls = i_rst_n && (r_state == S_IDLE) && bus.i_ls_req &&
                    (!bus.i_if_req || !r_last_ls);

  // The counter is loaded with WAIT_CYCLES at grant, so it still holds that
  // value only in the first ACCESS cycle: one write strobe per store.
  assign w_first = (r_cnt == 4'(WAIT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_bmask = '0;
    w_mem_wren  = 1'b0;
    w_if_rvalid = 1'b0;
    w_ls_rvalid = 1'b0;
    w_if_rdata  = '0;
    w_ls_rdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_if || w_gnt_ls) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        w_mem_bmask = r_bmask;
        w_mem_wren  = r_wren && w_first;
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_mem_addr  = r_addr;
        w_state_nxt = S_IDLE;
        if (r_own_ls) begin
          w_ls_rvalid = 1'b1;
          w_ls_rdata  = r_wren ? '0 : bus.i_mem_rdata;
        end else begin
          w_if_rvalid = 1'b1;
          w_if_rdata  = bus.i_mem_rdata;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured only on the grant edge; later input changes
  // cannot disturb the access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_ls <= 1'b0;
      r_own_ls  <= 1'b0;
      r_wren    <= 1'b0;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_bmask   <= '0;
    end else if (w_gnt_if || w_gnt_ls) begin
      r_last_ls <= w_gnt_ls;
      r_own_ls  <= w_gnt_ls;
      r_wren    <= w_gnt_ls && bus.i_ls_wren;
      r_cnt     <= 4'(WAIT_CYCLES);
      r_addr    <= w_gnt_ls ? bus.i_ls_addr  : bus.i_if_addr;
      r_wdata   <= w_gnt_ls ? bus.i_ls_wdata : '0;
      r_bmask   <= w_gnt_ls ? bus.i_ls_bmask : 4'd0;
    end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign bus.o_if_gnt    = w_gnt_if;
  assign bus.o_ls_gnt    = w_gnt_ls;
  assign bus.o_if_rvalid = w_if_rvalid;
  assign bus.o_ls_rvalid = w_ls_rvalid;
  assign bus.o_if_rdata  = w_if_rdata;
  assign bus.o_ls_rdata  = w_ls_rdata;
  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_wren  = w_mem_wren;
  assign bus.o_mem_wdata = w_mem_wdata;
  assign bus.o_mem_bmask = w_mem_bmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiters (WAIT_CYCLES 0, 2, 3) share one stimulus stream. A
// transaction-level model predicts every output each cycle from the grant
// cycle of the access in flight; directed steps add fixed-value checks.
module tb_mem_port_arbiter;
  localparam int NI = 3;
  localparam int TR = 2048;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req, ls_req, ls_wren;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_bmask;

  logic [NI-1:0]       o_ifg, o_lsg, o_ifv, o_lsv, o_wren;
  logic [NI-1:0][31:0] o_ifd, o_lsd, o_addr, o_wd;
  logic [NI-1:0][3:0]  o_bm;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_bus ();
    logic [31:0] mrd;
    assign u_bus.i_if_req    = if_req;
    assign u_bus.i_if_addr   = if_addr;
    assign u_bus.i_ls_req    = ls_req;
    assign u_bus.i_ls_wren   = ls_wren;
    assign u_bus.i_ls_addr   = ls_addr;
    assign u_bus.i_ls_wdata  = ls_wdata;
    assign u_bus.i_ls_bmask  = ls_bmask;
    assign u_bus.i_mem_rdata = mrd;
    always @(posedge clk) mrd <= memf(u_bus.o_mem_addr);
    assign o_ifg[g]  = u_bus.o_if_gnt;
    assign o_lsg[g]  = u_bus.o_ls_gnt;
    assign o_ifv[g]  = u_bus.o_if_rvalid;
    assign o_lsv[g]  = u_bus.o_ls_rvalid;
    assign o_ifd[g]  = u_bus.o_if_rdata;
    assign o_lsd[g]  = u_bus.o_ls_rdata;
    assign o_addr[g] = u_bus.o_mem_addr;
    assign o_wren[g] = u_bus.o_mem_wren;
    assign o_wd[g]   = u_bus.o_mem_wdata;
    assign o_bm[g]   = u_bus.o_mem_bmask;
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(wc(g))) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (u_bus)
    );
  end

  // model: one record per DUT describing the access in flight
  bit          busy [NI];
  int          tg [NI];
  bit          m_own_ls [NI], m_wr [NI], m_last_ls [NI];
  logic [31:0] m_addr [NI], m_wd [NI];
  logic [3:0]  m_bm [NI];

  // per-cycle traces for the directed fixed-value checks
  logic [NI-1:0]       tr_ifg [TR], tr_lsg [TR], tr_ifv [TR], tr_lsv [TR], tr_wren [TR];
  logic [NI-1:0][31:0] tr_addr [TR], tr_ifd [TR], tr_lsd [TR], tr_wd [TR];
  logic [NI-1:0][3:0]  tr_bm [TR];

  int n, checks, errors;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s w%0d cycle %0d: got 0x%08h expected 0x%08h", tag, wc(k), n, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_flags"}, k, {27'd0, o_ifg[k], o_lsg[k], o_ifv[k], o_lsv[k], o_wren[k]}, 32'd0);
      chk({tag, "_addr"}, k, o_addr[k], 32'd0);
      chk({tag, "_data"}, k, o_wd[k] | o_ifd[k] | o_lsd[k] | {28'd0, o_bm[k]}, 32'd0);
    end
  endtask

  // Check one cycle against the model at the falling edge, then advance.
  task automatic step();
    logic        e_ifg, e_lsg, e_ifv, e_lsv, e_wren;
    logic [31:0] e_ifd, e_lsd, e_addr, e_wd;
    logic [3:0]  e_bm;
    bit          idle, chk_wd, chk_bm;
    int          ph;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      {e_ifg, e_lsg, e_ifv, e_lsv, e_wren} = '0;
      e_ifd = '0; e_lsd = '0; e_addr = '0; e_wd = '0; e_bm = '0;
      chk_wd = 1'b1; chk_bm = 1'b1;
      idle = !busy[k] || (n >= tg[k] + 3 + wc(k));
      if (rst_n) begin
        if (idle) begin
          e_ifg = if_req && (!ls_req || m_last_ls[k]);
          e_lsg = ls_req && (!if_req || !m_last_ls[k]);
        end else begin
          ph = n - tg[k];
          e_addr = m_addr[k];
          if (ph <= 1 + wc(k)) begin
            e_wd   = m_wd[k];
            e_bm   = m_bm[k];
            e_wren = (ph == 1) && m_wr[k];
            chk_wd = m_own_ls[k];
          end else begin
            chk_wd = 1'b0; chk_bm = 1'b0;
            if (m_own_ls[k]) begin
              e_lsv = 1'b1;
              e_lsd = m_wr[k] ? 32'd0 : memf(m_addr[k]);
            end else begin
              e_ifv = 1'b1;
              e_ifd = memf(m_addr[k]);
            end
          end
        end
      end
      chk("if_gnt",    k, 32'(o_ifg[k]),  32'(e_ifg));
      chk("ls_gnt",    k, 32'(o_lsg[k]),  32'(e_lsg));
      chk("if_rvalid", k, 32'(o_ifv[k]),  32'(e_ifv));
      chk("ls_rvalid", k, 32'(o_lsv[k]),  32'(e_lsv));
      chk("if_rdata",  k, o_ifd[k],       e_ifd);
      chk("ls_rdata",  k, o_lsd[k],       e_lsd);
      chk("mem_addr",  k, o_addr[k],      e_addr);
      chk("mem_wren",  k, 32'(o_wren[k]), 32'(e_wren));
      if (chk_wd) chk("mem_wdata", k, o_wd[k], e_wd);
      if (chk_bm) chk("mem_bmask", k, 32'(o_bm[k]), 32'(e_bm));
      if (n < TR) begin
        tr_ifg[n][k] = o_ifg[k];  tr_lsg[n][k] = o_lsg[k];
        tr_ifv[n][k] = o_ifv[k];  tr_lsv[n][k] = o_lsv[k];
        tr_wren[n][k] = o_wren[k]; tr_addr[n][k] = o_addr[k];
        tr_ifd[n][k] = o_ifd[k];  tr_lsd[n][k] = o_lsd[k];
        tr_wd[n][k] = o_wd[k];    tr_bm[n][k] = o_bm[k];
      end
      if (!rst_n) begin
        busy[k] = 1'b0;
        m_last_ls[k] = 1'b0;
      end else if (idle && (e_ifg || e_lsg)) begin
        busy[k]      = 1'b1;
        tg[k]        = n;
        m_own_ls[k]  = e_lsg;
        m_last_ls[k] = e_lsg;
        m_wr[k]      = e_lsg && ls_wren;
        m_addr[k]    = e_lsg ? ls_addr : if_addr;
        m_wd[k]      = e_lsg ? ls_wdata : 32'd0;
        m_bm[k]      = e_lsg ? ls_bmask : 4'd0;
      end
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    int n0, n1, t, cnt;
    checks = 0; errors = 0; n = 0;
    rst_n = 1'b0;
    if_req = 0; ls_req = 0; ls_wren = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_bmask = 0;
    for (int k = 0; k < NI; k++) begin
      busy[k] = 0; tg[k] = 0; m_last_ls[k] = 0; m_own_ls[k] = 0; m_wr[k] = 0;
    end

    // reset state
    #2;
    chk_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // fetch read, addr 0x10
    n0 = n;
    if_req = 1; if_addr = 32'h10;
    step();
    if_req = 0;
    repeat (7) step();
    chk("t1_gnt",   0, 32'(tr_ifg[n0][0]),   32'd1);
    chk("t1_addr",  0, tr_addr[n0+1][0],     32'h10);
    chk("t1_rv",    0, 32'(tr_ifv[n0+2][0]), 32'd1);
    chk("t1_rdata", 0, tr_ifd[n0+2][0],      32'h00500093);
    chk("t1_idle",  0, tr_addr[n0+3][0],     32'd0);
    chk("t1_rv_w2", 1, 32'(tr_ifv[n0+4][1]), 32'd1);

    // simultaneous requests after reset: ls first, then strict alternation
    rst_n = 0; step(); rst_n = 1; step();
    n0 = n;
    if_req = 1; if_addr = 32'h0;
    ls_req = 1; ls_addr = 32'h7000; ls_wren = 0; ls_wdata = 32'h1234; ls_bmask = 4'h3;
    repeat (20) step();
    if_req = 0; ls_req = 0;
    repeat (8) step();
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < 4; j++) begin
        t = n0 + j * (3 + wc(k));
        if (j % 2 == 0) chk("t2_order_ls", k, 32'(tr_lsg[t][k]), 32'd1);
        else            chk("t2_order_if", k, 32'(tr_ifg[t][k]), 32'd1);
      end

    // store
    n0 = n;
    ls_req = 1; ls_wren = 1; ls_addr = 32'h7020; ls_wdata = 32'hDEADBEEF; ls_bmask = 4'hF;
    step();
    ls_req = 0;
    repeat (7) step();
    chk("t3_wren1", 0, 32'(tr_wren[n0+1][0]), 32'd1);
    chk("t3_wren2", 0, 32'(tr_wren[n0+2][0]), 32'd0);
    chk("t3_addr",  0, tr_addr[n0+1][0],      32'h7020);
    chk("t3_wdata", 0, tr_wd[n0+1][0],        32'hDEADBEEF);
    chk("t3_bmask", 0, 32'(tr_bm[n0+1][0]),   32'hF);
    chk("t3_rv",    0, 32'(tr_lsv[n0+2][0]),  32'd1);
    chk("t3_rdata", 0, tr_lsd[n0+2][0],       32'd0);
    cnt = 0;
    for (int c = 0; c < 8; c++) cnt += int'(tr_wren[n0+c][2]);
    chk("t3_wren_once", 2, cnt, 32'd1);

    // WAIT_CYCLES=2 load
    n0 = n;
    ls_req = 1; ls_wren = 0; ls_addr = 32'h7040; ls_wdata = 32'h55AA55AA; ls_bmask = 4'h1;
    step();
    ls_req = 0; ls_addr = 32'hFFFF_0000;
    repeat (7) step();
    for (int c = 1; c <= 4; c++) chk("t4_addr_hold", 1, tr_addr[n0+c][1], 32'h7040);
    chk("t4_rv_early", 1, 32'(tr_lsv[n0+3][1]), 32'd0);
    chk("t4_rv",       1, 32'(tr_lsv[n0+4][1]), 32'd1);
    chk("t4_rdata",    1, tr_lsd[n0+4][1],      memf(32'h7040));
    chk("t4_idle",     1, tr_addr[n0+5][1],     32'd0);

    // reset in the second ACCESS cycle
    n0 = n;
    ls_req = 1; ls_wren = 0; ls_addr = 32'h7080;
    step();
    ls_req = 0;
    step();
    if_req = 1; if_addr = 32'h300;
    rst_n = 0;
    #1;
    chk_zero("t5_async");
    step(); step();
    rst_n = 1;
    n1 = n;
    step();
    if_req = 0;
    repeat (7) step();
    chk("t5_gnt_after", 2, 32'(tr_ifg[n1][2]), 32'd1);
    for (int c = n0 + 2; c < n1 + 8; c++) chk("t5_no_rv", 2, 32'(tr_lsv[c][2]), 32'd0);

    // fetch request withdrawn before it can be granted
    n0 = n;
    ls_req = 1; ls_wren = 0; ls_addr = 32'h7100;
    step();
    ls_req = 0; if_req = 1; if_addr = 32'h200;
    step();
    if_req = 0;
    repeat (7) step();
    for (int k = 0; k < NI; k++) begin
      cnt = 0;
      for (int c = n0; c < n0 + 9; c++)
        cnt += int'(tr_ifg[c][k]) + int'(tr_addr[c][k] == 32'h200);
      chk("t6_withdrawn", k, cnt, 32'd0);
    end

    // randomized traffic, occasional reset
    repeat (400) begin
      if_req   = ($urandom_range(0, 2) != 0);
      ls_req   = ($urandom_range(0, 2) != 0);
      ls_wren  = $urandom_range(0, 1) == 1;
      if_addr  = $urandom & 32'hFFFC;
      ls_addr  = $urandom & 32'hFFFC;
      ls_wdata = $urandom;
      ls_bmask = 4'($urandom_range(0, 15));
      rst_n    = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1; if_req = 0; ls_req = 0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
